multi_gate_lot_counter: RTL and testbench
=========================================

MULTI_GATE_LOT_COUNTER -- requirements
Module: multi_gate_lot_counter

Interface
REQ-001 The block SHALL have parameter GATES, default 2, number of independent gate sensor pairs (legal range 1..8).
REQ-002 The block SHALL have parameter CAPACITY, default 25, maximum lot occupancy (legal range 1..255).
REQ-003 The block SHALL have localparam CW = $clog2(CAPACITY+1), the count width.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous and active-high reset.
REQ-006 The block SHALL have port a, input, GATES, outer beam sensor per gate (1 = blocked), asynchronous to clock.
REQ-007 The block SHALL have port b, input, GATES, inner beam sensor per gate (1 = blocked), asynchronous to clock.
REQ-008 The block SHALL have port count, output, CW, current occupancy.
REQ-009 The block SHALL have port full, output, 1, high when count == CAPACITY.
REQ-010 The block SHALL have port empty, output, 1, high when count == 0.
REQ-011 The block SHALL have port enter_pulse, output, GATES, one-cycle pulse per accepted entry.
REQ-012 The block SHALL have port exit_pulse, output, GATES, one-cycle pulse per accepted exit.
REQ-013 The block SHALL have port reject_pulse, output, GATES, one-cycle pulse per entry refused because the lot is full.
REQ-014 The block SHALL have port underflow_pulse, output, GATES, one-cycle pulse per exit seen while the lot is empty.
REQ-015 The block SHALL have port seq_err, output, GATES, one-cycle pulse on an illegal sensor transition.

Function
REQ-016 Each a[i] and b[i] SHALL pass through a 2-flop synchronizer; the gate FSM uses only the synchronized pair {a,b}.
REQ-017 Each gate SHALL run an independent FSM with states IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR.
REQ-018 Entry path SHALL be: IDLE-10->EN1, EN1-11->EN2, EN2-01->EN3, EN3-00->IDLE, with completion raising an entry event.
REQ-019 Exit path SHALL be: IDLE-01->EX1, EX1-11->EX2, EX2-10->EX3, EX3-00->IDLE, with completion raising an exit event.
REQ-020 A vehicle backing out SHALL step the FSM back one state (EN2-10->EN1, EN3-11->EN2, EX2-01->EX1, EX3-11->EX2), and EN1/EX1 seeing 00 SHALL return to IDLE with no event.
REQ-021 An unchanged input SHALL hold the current state.
REQ-022 Any other input SHALL move the FSM to ERR and pulse seq_err[i] for one cycle; ERR SHALL hold until 00, then go to IDLE with no event.
REQ-023 Latency: raw 00 sampled at edge k that completes a sequence SHALL make the pulse and the count update visible after edge k+2.
REQ-024 Per cycle, exits SHALL be accepted in gate-index order (lowest index first) while count minus already-accepted exits > 0; remaining exits SHALL get underflow_pulse instead of exit_pulse.
REQ-025 Entries SHALL be accepted in gate-index order (lowest index first) while count minus accepted exits plus accepted entries < CAPACITY; remaining entries SHALL get reject_pulse instead of enter_pulse.
REQ-026 Next count SHALL be count − accepted exits + accepted entries, and SHALL never wrap below 0 or exceed CAPACITY.
REQ-027 full and empty SHALL be registered and consistent with count on the same cycle.
REQ-028 At most one of enter_pulse[i], exit_pulse[i], reject_pulse[i], underflow_pulse[i], seq_err[i] SHALL be high per gate per cycle.

Reset
REQ-029 While reset is high at an edge, all FSMs SHALL go to IDLE, synchronizer flops SHALL clear to 0, count SHALL be 0, empty SHALL be 1, full SHALL be 0, and all pulse outputs SHALL be 0.
REQ-030 Reset asserted mid-sequence SHALL discard the partial sequence with no event, and reset SHALL override any event completing on the same edge.
REQ-031 After reset deasserts, the FSMs SHALL resume from the synchronized sensor values, so a pair that is not 00 leads to ERR per REQ-022.

Verification
REQ-032 (GATES=2, CAPACITY=3) Reset, then gate0 00,10,11,01,00 SHALL give enter_pulse=01 two cycles after the final 00, count=1, and empty falling.
REQ-033 Gate0 exit 00,01,11,10,00 at count=1 SHALL give exit_pulse=01, count=0, empty=1; a second exit SHALL give underflow_pulse=01 with count staying 0.
REQ-034 Three entries SHALL give count=3 and full=1; a fourth entry SHALL give reject_pulse and count staying 3.
REQ-035 At count=3, gate0 exit and gate1 entry completing on the same edge SHALL give exit_pulse=01, enter_pulse=10, and count=3.
REQ-036 Gate1 00,11 SHALL give seq_err=10 and no count change; 10,11,10,11,01,00 (back-off) SHALL stay in ERR until the first 00 returns gate1 to IDLE with no entry counted.
REQ-037 Reset pulsed during gate0 EN2 with count=2 SHALL give count=0 and no enter_pulse when the sequence later completes.

Source files
------------

// File: rtl/multi_gate_lot_counter.sv
// Parking-lot occupancy counter fed by per-gate two-beam sensor pairs.
// Each gate decodes entry/exit sequences; a shared arbiter settles count changes.
module multi_gate_lot_counter #(
  parameter int GATES    = 2,
  parameter int CAPACITY = 25,
  localparam int CW      = $clog2(CAPACITY + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [GATES-1:0] a,
  input  logic [GATES-1:0] b,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [GATES-1:0] enter_pulse,
  output logic [GATES-1:0] exit_pulse,
  output logic [GATES-1:0] reject_pulse,
  output logic [GATES-1:0] underflow_pulse,
  output logic [GATES-1:0] seq_err
);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR} state_t;

  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  logic [GATES-1:0] a_meta, a_sync, b_meta, b_sync;
  state_t           state    [GATES];
  state_t           state_nx [GATES];
  logic [GATES-1:0] ent_ev, ext_ev, err_ev;
  logic [GATES-1:0] enter_nx, exit_nx, reject_nx, underflow_nx;
  logic [CW-1:0]    count_nx;

  // Per-gate sequence decoder; pair is {outer, inner} after synchronization.
  always_comb begin
    logic [1:0] pair;
    pair = 2'b00;
    for (int i = 0; i < GATES; i++) begin
      // NOTE: every output of this block gets a default before the case, so no latch is inferred.
      state_nx[i] = state[i];
      ent_ev[i]   = 1'b0;
      ext_ev[i]   = 1'b0;
      err_ev[i]   = 1'b0;
      pair        = {a_sync[i], b_sync[i]};
      case (state[i])
        IDLE: case (pair)
          2'b10:   state_nx[i] = EN1;
          2'b01:   state_nx[i] = EX1;
          2'b11:   begin state_nx[i] = ERR; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EN1: case (pair)
          2'b11:   state_nx[i] = EN2;
          2'b00:   state_nx[i] = IDLE;
          2'b01:   begin state_nx[i] = ERR; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EN2: case (pair)
          2'b01:   state_nx[i] = EN3;
          2'b10:   state_nx[i] = EN1;
          2'b00:   begin state_nx[i] = ERR; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EN3: case (pair)
          2'b00:   begin state_nx[i] = IDLE; ent_ev[i] = 1'b1; end
          2'b11:   state_nx[i] = EN2;
          2'b10:   begin state_nx[i] = ERR; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EX1: case (pair)
          2'b11:   state_nx[i] = EX2;
          2'b00:   state_nx[i] = IDLE;
          2'b10:   begin state_nx[i] = ERR; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EX2: case (pair)
          2'b10:   state_nx[i] = EX3;
          2'b01:   state_nx[i] = EX1;
          2'b00:   begin state_nx[i] = ERR; err_ev[i] = 1'b1; end
          default: ;
        endcase
        EX3: case (pair)
          2'b00:   begin state_nx[i] = IDLE; ext_ev[i] = 1'b1; end
          2'b11:   state_nx[i] = EX2;
          2'b01:   begin state_nx[i] = ERR; err_ev[i] = 1'b1; end
          default: ;
        endcase
        default: if (pair == 2'b00) state_nx[i] = IDLE;
      endcase
    end
  end

  // Exits are settled first, then entries, each in ascending gate order.
  always_comb begin
    logic [CW-1:0] lvl;
    // NOTE: lvl is a running total within one evaluation, so blocking '=' is intended here.
    lvl          = count;
    enter_nx     = '0;
    exit_nx      = '0;
    reject_nx    = '0;
    underflow_nx = '0;
    for (int i = 0; i < GATES; i++) begin
      if (ext_ev[i]) begin
        if (lvl != '0) begin
          exit_nx[i] = 1'b1;
          lvl        = lvl - 1'b1;
        end else begin
          underflow_nx[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < GATES; i++) begin
      if (ent_ev[i]) begin
        if (lvl < CAP) begin
          enter_nx[i] = 1'b1;
          lvl         = lvl + 1'b1;
        end else begin
          reject_nx[i] = 1'b1;
        end
      end
    end
    count_nx = lvl;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_meta          <= '0;
      a_sync          <= '0;
      b_meta          <= '0;
      b_sync          <= '0;
      for (int i = 0; i < GATES; i++) state[i] <= IDLE;
      count           <= '0;
      full            <= 1'b0;
      empty           <= 1'b1;
      enter_pulse     <= '0;
      exit_pulse      <= '0;
      reject_pulse    <= '0;
      underflow_pulse <= '0;
      seq_err         <= '0;
    end else begin
      a_meta          <= a;
      a_sync          <= a_meta;
      b_meta          <= b;
      b_sync          <= b_meta;
      for (int i = 0; i < GATES; i++) state[i] <= state_nx[i];
      count           <= count_nx;
      full            <= (count_nx == CAP);
      empty           <= (count_nx == '0);
      enter_pulse     <= enter_nx;
      exit_pulse      <= exit_nx;
      reject_pulse    <= reject_nx;
      underflow_pulse <= underflow_nx;
      seq_err         <= err_ev;
    end
  end

endmodule

// File: tb/tb_multi_gate_lot_counter.sv
// Self-checking bench: directed lot scenarios plus random sensor walks,
// compared every cycle against a track-position model of the gates.
module tb_multi_gate_lot_counter;

  localparam int G   = 2;
  localparam int CAP = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic [G-1:0] a, b;
  logic [1:0]   count;
  logic         full, empty;
  logic [G-1:0] enter_pulse, exit_pulse, reject_pulse, underflow_pulse, seq_err;

  multi_gate_lot_counter #(.GATES(G), .CAPACITY(CAP)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .count(count), .full(full),
    .empty(empty), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
    .reject_pulse(reject_pulse), .underflow_pulse(underflow_pulse), .seq_err(seq_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a gate walks a 4-position cyclic track (0 = clear); mode 0 idle,
  // 1 entry track, 2 exit track, 3 error. Wrapping 3 -> 0 forward completes.
  int         m_mode [G];
  int         m_pos  [G];
  logic [1:0] m_s1   [G];
  logic [1:0] m_s2   [G];
  int         m_count;
  logic [G-1:0] m_ent, m_ext, m_rej, m_und, m_err;

  function automatic logic [1:0] pair_of(input int mode, input int pos);
    logic [1:0] en_trk [4];
    logic [1:0] ex_trk [4];
    en_trk = '{2'b00, 2'b10, 2'b11, 2'b01};
    ex_trk = '{2'b00, 2'b01, 2'b11, 2'b10};
    return (mode == 1) ? en_trk[pos] : ex_trk[pos];
  endfunction

  function automatic int idx_of(input int mode, input logic [1:0] p);
    for (int k = 0; k < 4; k++) if (pair_of(mode, k) == p) return k;
    return 0;
  endfunction

  task automatic model_step();
    int ev [G];
    int lvl, idx, d;
    logic [1:0] p;
    m_ent = '0; m_ext = '0; m_rej = '0; m_und = '0; m_err = '0;
    if (reset) begin
      for (int g = 0; g < G; g++) begin
        m_mode[g] = 0; m_pos[g] = 0; m_s1[g] = 2'b00; m_s2[g] = 2'b00;
      end
      m_count = 0;
      return;
    end
    for (int g = 0; g < G; g++) begin
      ev[g] = 0;
      p = m_s2[g];
      if (m_mode[g] == 3) begin
        if (p == 2'b00) m_mode[g] = 0;
      end else if (m_mode[g] == 0) begin
        if (p == 2'b10)      begin m_mode[g] = 1; m_pos[g] = 1; end
        else if (p == 2'b01) begin m_mode[g] = 2; m_pos[g] = 1; end
        else if (p == 2'b11) begin m_mode[g] = 3; ev[g] = 3; end
      end else begin
        idx = idx_of(m_mode[g], p);
        d   = (idx - m_pos[g] + 4) % 4;
        if (d == 1) begin
          if (idx == 0) begin ev[g] = m_mode[g]; m_mode[g] = 0; end
          else m_pos[g] = idx;
        end else if (d == 3) begin
          m_pos[g] = idx;
          if (idx == 0) m_mode[g] = 0;
        end else if (d == 2) begin
          m_mode[g] = 3; ev[g] = 3;
        end
      end
    end
    lvl = m_count;
    for (int g = 0; g < G; g++) begin
      if (ev[g] == 3) m_err[g] = 1'b1;
      if (ev[g] == 2) begin
        if (lvl > 0) begin m_ext[g] = 1'b1; lvl--; end
        else m_und[g] = 1'b1;
      end
    end
    for (int g = 0; g < G; g++) begin
      if (ev[g] == 1) begin
        if (lvl < CAP) begin m_ent[g] = 1'b1; lvl++; end
        else m_rej[g] = 1'b1;
      end
    end
    m_count = lvl;
    for (int g = 0; g < G; g++) begin
      m_s2[g] = m_s1[g];
      m_s1[g] = {a[g], b[g]};
    end
  endtask

  task automatic compare_all();
    check("count", count, m_count);
    check("full", full, (m_count == CAP));
    check("empty", empty, (m_count == 0));
    check("enter_pulse", enter_pulse, m_ent);
    check("exit_pulse", exit_pulse, m_ext);
    check("reject_pulse", reject_pulse, m_rej);
    check("underflow_pulse", underflow_pulse, m_und);
    check("seq_err", seq_err, m_err);
  endtask

  logic [G-1:0] cur_a = '0, cur_b = '0;
  logic         rst_v = 1'b1;

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      a = cur_a; b = cur_b; reset = rst_v;
      @(posedge clock);
      model_step();
      #1;
      compare_all();
    end
  endtask

  task automatic setp(input int g, input logic [1:0] p);
    cur_a[g] = p[1];
    cur_b[g] = p[0];
  endtask

  // Walks one gate through a list of pairs, one cycle each, then holds 00
  // long enough for the completion to reach the outputs.
  task automatic walk(input int g, input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2);
    setp(g, p0); run(1);
    setp(g, p1); run(1);
    setp(g, p2); run(1);
    setp(g, 2'b00); run(3);
  endtask

  int w_mode [G];
  int w_pos  [G];

  initial begin
    reset = 1'b1; a = '0; b = '0;
    run(3);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    rst_v = 1'b0;
    run(2);

    walk(0, 2'b10, 2'b11, 2'b01);
    check("entry_pulse", enter_pulse, 2'b01);
    check("entry_count", count, 1);
    check("entry_empty", empty, 0);

    walk(0, 2'b01, 2'b11, 2'b10);
    check("exit_pulse", exit_pulse, 2'b01);
    check("exit_empty", empty, 1);
    walk(0, 2'b01, 2'b11, 2'b10);
    check("underflow", underflow_pulse, 2'b01);
    check("underflow_count", count, 0);

    for (int k = 0; k < 3; k++) walk(0, 2'b10, 2'b11, 2'b01);
    check("fill_count", count, 3);
    check("fill_full", full, 1);
    walk(0, 2'b10, 2'b11, 2'b01);
    check("reject", reject_pulse, 2'b01);
    check("reject_count", count, 3);

    setp(0, 2'b01); setp(1, 2'b10); run(1);
    setp(0, 2'b11); setp(1, 2'b11); run(1);
    setp(0, 2'b10); setp(1, 2'b01); run(1);
    setp(0, 2'b00); setp(1, 2'b00); run(3);
    check("swap_exit", exit_pulse, 2'b01);
    check("swap_enter", enter_pulse, 2'b10);
    check("swap_count", count, 3);

    setp(1, 2'b11); run(3);
    check("seq_err", seq_err, 2'b10);
    setp(1, 2'b10); run(1);
    setp(1, 2'b11); run(1);
    walk(1, 2'b10, 2'b11, 2'b01);
    check("err_no_entry", enter_pulse, 2'b00);
    check("err_count", count, 3);

    walk(0, 2'b01, 2'b11, 2'b10);
    check("two_count", count, 2);
    setp(0, 2'b10); run(1);
    setp(0, 2'b11); run(3);
    rst_v = 1'b1; run(1);
    check("midrst_count", count, 0);
    rst_v = 1'b0;
    setp(0, 2'b01); run(1);
    setp(0, 2'b00); run(4);
    check("midrst_noentry", enter_pulse, 2'b00);
    check("midrst_final", count, 0);

    for (int g = 0; g < G; g++) begin w_mode[g] = 0; w_pos[g] = 0; end
    for (int c = 0; c < 4000; c++) begin
      for (int g = 0; g < G; g++) begin
        int r;
        if ($urandom_range(0, 9) < 5) continue;
        r = $urandom_range(0, 19);
        if (r < 14) begin
          if (w_mode[g] == 0) begin w_mode[g] = $urandom_range(1, 2); w_pos[g] = 0; end
          w_pos[g] = (w_pos[g] + 1) % 4;
          if (w_pos[g] == 0) w_mode[g] = 0;
        end else if (r < 18) begin
          if (w_mode[g] != 0) begin
            w_pos[g]--;
            if (w_pos[g] == 0) w_mode[g] = 0;
          end
        end else begin
          w_mode[g] = 0; w_pos[g] = 0;
          setp(g, 2'($urandom_range(0, 3)));
          continue;
        end
        setp(g, (w_mode[g] == 0) ? 2'b00 : pair_of(w_mode[g], w_pos[g]));
      end
      rst_v = ($urandom_range(0, 299) == 0);
      run(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
